// File: rtl/ysyx_22050039_lsu.sv
// Load/store unit: one byte-lane-aligned access at a time on a valid/ready data bus.
// state | meaning: IDLE accept request | REQ bus request pending | WAIT awaiting rsp | RESP result to writeback
module ysyx_22050039_lsu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_wen,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic              wen_q, wen_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [2:0]        off_q, off_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              misal;
  logic [7:0]        base;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   ext;

  always_comb begin
    unique case (in_size)
      2'd0:    begin base = 8'h01; misal = 1'b0; end
      2'd1:    begin base = 8'h03; misal = in_addr[0]; end
      2'd2:    begin base = 8'h0F; misal = |in_addr[1:0]; end
      default: begin base = 8'hFF; misal = |in_addr[2:0]; end
    endcase
  end

  // Right-justify the addressed lanes, then extend to XLEN.
  always_comb begin
    raw = mem_rsp_data >> {off_q, 3'b000};
    unique case (size_q)
      2'd0:    ext = uns_q ? {{(XLEN-8){1'b0}},  raw[7:0]}  : {{(XLEN-8){raw[7]}},   raw[7:0]};
      2'd1:    ext = uns_q ? {{(XLEN-16){1'b0}}, raw[15:0]} : {{(XLEN-16){raw[15]}}, raw[15:0]};
      2'd2:    ext = uns_q ? {{(XLEN-32){1'b0}}, raw[31:0]} : {{(XLEN-32){raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    wen_d         = wen_q;
    size_d        = size_q;
    uns_d         = uns_q;
    off_d         = off_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wen_d   = in_wen;
          size_d  = in_size;
          uns_d   = in_unsigned;
          off_d   = in_addr[2:0];
          addr_d  = {in_addr[XLEN-1:3], 3'b000};
          wdata_d = in_wdata << {in_addr[2:0], 3'b000};
          wmask_d = in_wen ? (base << in_addr[2:0]) : 8'h00;
          rdata_d = '0;
          err_d   = misal;
          state_d = misal ? RESP : REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = wen_q ? '0 : ext;
          state_d = RESP;
        end
      end
      default: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      off_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= 8'h00;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign out_rdata = rdata_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Directed bench for the LSU: byte-lane model plus hand-computed literal checks.
module tb_ysyx_22050039_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_wen = 1'b0, in_unsigned = 1'b0;
  logic [1:0]  in_size = 2'd0;
  logic [63:0] in_addr = '0, in_wdata = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = '0;
  logic        out_valid, out_ready = 1'b0, out_err;
  logic [63:0] out_rdata;

  int n_cmp = 0;
  int n_fail = 0;
  int bus_hs = 0;

  bit          exp_req_ok = 1'b0, exp_out_ok = 1'b0;
  logic [63:0] exp_addr, exp_wdata, exp_rdata;
  logic [7:0]  exp_wmask;
  logic        exp_wen, exp_err;

  ysyx_22050039_lsu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Model: an access covers 2**size bytes starting at lane addr%8.
  function automatic bit m_misal(input logic [1:0] size, input logic [63:0] addr);
    return (addr % (64'd1 << size)) != 0;
  endfunction

  function automatic logic [7:0] m_mask(input bit wen, input logic [1:0] size, input logic [63:0] addr);
    logic [7:0] m = '0;
    int off = int'(addr % 8);
    if (wen) for (int i = 0; i < (1 << size); i++) m[off + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_rdata(input bit wen, input logic [1:0] size, input bit uns,
                                          input logic [63:0] addr, input logic [63:0] rsp);
    logic [63:0] v = '0;
    int n = 1 << size;
    int off = int'(addr % 8);
    if (wen) return '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rsp[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1]) v = v - (64'd1 << (8*n));
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (mem_req_valid) begin
        chk("req_expected", 64'(exp_req_ok), 64'd1);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wen", 64'(mem_wen), 64'(exp_wen));
        chk("mem_wmask", 64'(mem_wmask), 64'(exp_wmask));
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (mem_req_ready) bus_hs++;
      end
      if (out_valid) begin
        chk("out_expected", 64'(exp_out_ok), 64'd1);
        chk("out_rdata", out_rdata, exp_rdata);
        chk("out_err", 64'(out_err), 64'(exp_err));
        chk("in_ready_resp", 64'(in_ready), 64'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_err"}, 64'(out_err), 64'd0);
    chk({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
    chk({tag, "_wmask"}, 64'(mem_wmask), 64'd0);
    chk({tag, "_rdata"}, out_rdata, 64'd0);
    chk({tag, "_addr"}, mem_addr, 64'd0);
    chk({tag, "_wdata"}, mem_wdata, 64'd0);
  endtask

  // Called at posedge+1 with the DUT idle.
  task automatic txn(input bit wen, input logic [1:0] size, input bit uns,
                     input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rsp,
                     input int req_stall, input int rsp_dly, input int out_stall,
                     input bit lit, input logic [63:0] lit_addr, input logic [7:0] lit_wmask,
                     input logic [63:0] lit_wdata, input logic [63:0] lit_rdata, input bit lit_err);
    bit mis = m_misal(size, addr);
    int hs0 = bus_hs;
    exp_addr  = addr & ~64'h7;
    exp_wen   = wen;
    exp_wmask = m_mask(wen, size, addr);
    exp_wdata = wdata << (8 * (addr % 8));
    exp_rdata = mis ? 64'd0 : m_rdata(wen, size, uns, addr, rsp);
    exp_err   = mis;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_wen = wen; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata;
    @(posedge clk); #1;
    in_valid = 1'b0; in_addr = ~addr; in_wdata = ~wdata; in_unsigned = ~uns;
    if (mis) begin
      exp_out_ok = 1'b1;
      chk("misal_no_req", 64'(mem_req_valid), 64'd0);
      chk("misal_latency", 64'(out_valid), 64'd1);
    end else begin
      exp_req_ok = 1'b1;
      chk("req_latency", 64'(mem_req_valid), 64'd1);
      if (lit) begin
        chk("lit_addr", mem_addr, lit_addr);
        chk("lit_wmask", 64'(mem_wmask), 64'(lit_wmask));
        chk("lit_wdata", mem_wdata, lit_wdata);
      end
      repeat (req_stall) begin @(posedge clk); #1; end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0; exp_req_ok = 1'b0;
      repeat (rsp_dly) begin @(posedge clk); #1; end
      chk("no_early_out", 64'(out_valid), 64'd0);
      mem_rsp_valid = 1'b1; mem_rsp_data = rsp;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0; mem_rsp_data = 64'h5A5A_A5A5_1234_8765;
      exp_out_ok = 1'b1;
      chk("rsp_latency", 64'(out_valid), 64'd1);
    end
    if (lit) begin
      chk("lit_rdata", out_rdata, lit_rdata);
      chk("lit_err", 64'(out_err), 64'(lit_err));
    end
    repeat (out_stall) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; exp_out_ok = 1'b0;
    chk("out_drop", 64'(out_valid), 64'd0);
    chk("bus_count", 64'(bus_hs - hs0), mis ? 64'd0 : 64'd1);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // LD
    txn(1'b0, 2'd3, 1'b0, 64'h80000008, 64'd0, 64'h1122334455667788, 0, 0, 0,
        1'b1, 64'h80000008, 8'h00, 64'd0, 64'h1122334455667788, 1'b0);
    // LB / LBU
    txn(1'b0, 2'd0, 1'b0, 64'h80000003, 64'd0, 64'h00000000F0000000, 0, 0, 0,
        1'b1, 64'h80000000, 8'h00, 64'd0, 64'hFFFFFFFFFFFFFFF0, 1'b0);
    txn(1'b0, 2'd0, 1'b1, 64'h80000003, 64'd0, 64'h00000000F0000000, 0, 1, 0,
        1'b1, 64'h80000000, 8'h00, 64'd0, 64'h00000000000000F0, 1'b0);
    // SH
    txn(1'b1, 2'd1, 1'b0, 64'h80000006, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0,
        1'b1, 64'h80000000, 8'hC0, 64'hABCD000000000000, 64'd0, 1'b0);
    // Misaligned LW
    txn(1'b0, 2'd2, 1'b0, 64'h80000002, 64'd0, 64'd0, 0, 0, 0,
        1'b1, 64'd0, 8'h00, 64'd0, 64'd0, 1'b1);
    // Backpressure on both sides
    txn(1'b1, 2'd2, 1'b0, 64'h8000000C, 64'h12345678, 64'd0, 3, 0, 2,
        1'b1, 64'h80000008, 8'hF0, 64'h1234567800000000, 64'd0, 1'b0);
    // LH high lanes, delayed response
    txn(1'b0, 2'd1, 1'b0, 64'h8000000E, 64'd0, 64'h8001000000000000, 0, 2, 0,
        1'b1, 64'h80000008, 8'h00, 64'd0, 64'hFFFFFFFFFFFF8001, 1'b0);
    // LWU / LW
    txn(1'b0, 2'd2, 1'b1, 64'h80000004, 64'd0, 64'hDEADBEEF00000000, 1, 0, 1,
        1'b1, 64'h80000000, 8'h00, 64'd0, 64'h00000000DEADBEEF, 1'b0);
    txn(1'b0, 2'd2, 1'b0, 64'h80000004, 64'd0, 64'hDEADBEEF00000000, 0, 0, 0,
        1'b1, 64'h80000000, 8'h00, 64'd0, 64'hFFFFFFFFDEADBEEF, 1'b0);
    // Misaligned SD / LHU
    txn(1'b1, 2'd3, 1'b0, 64'h80000004, 64'h1111, 64'd0, 0, 0, 1,
        1'b1, 64'd0, 8'h00, 64'd0, 64'd0, 1'b1);
    txn(1'b0, 2'd1, 1'b1, 64'h00000001, 64'd0, 64'd0, 0, 0, 0,
        1'b1, 64'd0, 8'h00, 64'd0, 64'd0, 1'b1);
    // SB top lane, and a model-only SD
    txn(1'b1, 2'd0, 1'b0, 64'h00000007, 64'h5A, 64'd0, 0, 0, 0,
        1'b1, 64'h00000000, 8'h80, 64'h5A00000000000000, 64'd0, 1'b0);
    txn(1'b1, 2'd3, 1'b0, 64'h80000020, 64'h0102030405060708, 64'd0, 1, 1, 1,
        1'b0, 64'd0, 8'h00, 64'd0, 64'd0, 1'b0);

    // Reset while waiting on a store's response
    exp_addr = 64'h80000018; exp_wen = 1'b1; exp_wmask = 8'hFF; exp_wdata = 64'hCAFEF00D12345678;
    in_valid = 1'b1; in_wen = 1'b1; in_size = 2'd3; in_unsigned = 1'b0;
    in_addr = 64'h80000018; in_wdata = 64'hCAFEF00D12345678;
    @(posedge clk); #1;
    in_valid = 1'b0; exp_req_ok = 1'b1; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; exp_req_ok = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check_all_zero("rst_wait");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    repeat (2) begin
      chk("late_rsp_ignored", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    txn(1'b0, 2'd2, 1'b0, 64'h80000010, 64'd0, 64'h000000007FFFFFFF, 0, 0, 0,
        1'b1, 64'h80000010, 8'h00, 64'd0, 64'h000000007FFFFFFF, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
